// File: rtl/word_32_bit_uart_tx.sv
// word_32_bit_uart_tx
// Serialises one 32-bit word as eight 8N1 UART bytes, interleaving a tag byte
// before each data byte: 0x01, word[7:0], 0x02, word[15:8], 0x03, word[23:16],
// 0x04, word[31:24]. Bytes are sent back-to-back with no idle gap.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   start  - request to send; accepted only while busy=0
//   word   - word to send; captured in the accepting cycle only
//   tx     - UART serial line, idle high (registered)
//   busy   - high while a word transfer is in progress (registered)
//   done   - one-cycle pulse in the cycle after the last stop bit (registered)
module word_32_bit_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, DATA = 2'd2} byte_state_t;
  typedef enum logic [1:0] {START = 2'd0, BITS = 2'd1, STOP = 2'd2} bit_state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  byte_state_t byte_state_r, byte_state_s;
  bit_state_t  bit_state_r, bit_state_s;
  logic [1:0]  byte_idx_r, byte_idx_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [15:0] baud_cnt_r, baud_cnt_s;
  logic [31:0] word_r, word_s;
  logic        tx_r, tx_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [7:0]  cur_byte_s;
  logic [2:0]  bit_next_s;

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

  // Byte currently on the line: tag (index+1) or the selected data slice.
  always_comb begin
    cur_byte_s = 8'd0;
    if (byte_state_r == TAG) begin
      cur_byte_s = {6'd0, byte_idx_r} + 8'd1;
    end else begin
      cur_byte_s = word_r[{byte_idx_r, 3'b000} +: 8];
    end
    bit_next_s = bit_idx_r + 3'd1;
  end

  // State register; outputs are registered copies of the next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_state_r <= IDLE;
      bit_state_r  <= START;
      byte_idx_r   <= 2'd0;
      bit_idx_r    <= 3'd0;
      baud_cnt_r   <= 16'd0;
      word_r       <= 32'd0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_state_r <= byte_state_s;
      bit_state_r  <= bit_state_s;
      byte_idx_r   <= byte_idx_s;
      bit_idx_r    <= bit_idx_s;
      baud_cnt_r   <= baud_cnt_s;
      word_r       <= word_s;
      tx_r         <= tx_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  // Next-state logic for the byte and bit FSMs. tx_s is the line level for
  // the following cycle, so each bit boundary loads the next bit's value.
  always_comb begin
    byte_state_s = byte_state_r;
    bit_state_s  = bit_state_r;
    byte_idx_s   = byte_idx_r;
    bit_idx_s    = bit_idx_r;
    baud_cnt_s   = baud_cnt_r;
    word_s       = word_r;
    tx_s         = tx_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    case (byte_state_r)
      IDLE: begin
        tx_s        = 1'b1;
        busy_s      = 1'b0;
        bit_state_s = START;
        bit_idx_s   = 3'd0;
        baud_cnt_s  = 16'd0;
        byte_idx_s  = 2'd0;
        if (start) begin
          // First start bit goes out in the very next cycle.
          byte_state_s = TAG;
          word_s       = word;
          tx_s         = 1'b0;
          busy_s       = 1'b1;
        end else begin
          byte_state_s = IDLE;
        end
      end
      TAG, DATA: begin
        busy_s = 1'b1;
        if (baud_cnt_r != BAUD_LAST) begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end else begin
          baud_cnt_s = 16'd0;
          case (bit_state_r)
            START: begin
              bit_state_s = BITS;
              bit_idx_s   = 3'd0;
              tx_s        = cur_byte_s[0];
            end
            BITS: begin
              if (bit_idx_r == 3'd7) begin
                bit_state_s = STOP;
                tx_s        = 1'b1;
              end else begin
                bit_idx_s = bit_next_s;
                tx_s      = cur_byte_s[bit_next_s];
              end
            end
            STOP: begin
              // End of byte: chain directly into the next start bit.
              bit_state_s = START;
              bit_idx_s   = 3'd0;
              if (byte_state_r == TAG) begin
                byte_state_s = DATA;
                tx_s         = 1'b0;
              end else if (byte_idx_r != 2'd3) begin
                byte_state_s = TAG;
                byte_idx_s   = byte_idx_r + 2'd1;
                tx_s         = 1'b0;
              end else begin
                byte_state_s = IDLE;
                byte_idx_s   = 2'd0;
                tx_s         = 1'b1;
                busy_s       = 1'b0;
                done_s       = 1'b1;
              end
            end
            default: begin
              byte_state_s = IDLE;
              bit_state_s  = START;
              tx_s         = 1'b1;
              busy_s       = 1'b0;
            end
          endcase
        end
      end
      default: begin
        byte_state_s = IDLE;
        bit_state_s  = START;
        tx_s         = 1'b1;
        busy_s       = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/word_32_bit_uart_tx.md
WORD_32_BIT_UART_TX -- requirements
Module: word_32_bit_uart_tx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002: clk  input  1  system clock; all logic on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: start  input  1  request to send word; sampled every cycle.
REQ-005: word  input  32  word to transmit; sampled only in the cycle start is accepted.
REQ-006: tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-007: busy  output  1  high while a word transfer is in progress, registered.
REQ-008: done  output  1  one-cycle pulse when the last stop bit of a word completes, registered.

Function
REQ-009: The block SHALL accept start only when busy=0, and SHALL latch word into an internal 32-bit register in that cycle.
REQ-010: start while busy=1 SHALL be ignored; changes on word after acceptance SHALL have no effect.
REQ-011: Per accepted word, the block SHALL send 8 bytes in this order: 0x01, word[7:0], 0x02, word[15:8], 0x03, word[23:16], 0x04, word[31:24].
REQ-012: Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles.
REQ-013: Bytes SHALL be sent back-to-back, with no idle time between one stop bit and the next start bit.
REQ-014: busy and the start bit of byte 0x01 SHALL both go high/low, respectively, in the cycle after start is accepted (latency 1).
REQ-015: A full word SHALL occupy exactly 80*CLKS_PER_BIT cycles of tx, from the first start-bit cycle through the last stop-bit cycle.
REQ-016: In the cycle after the last stop-bit cycle, done=1 and busy=0 SHALL both hold, with tx=1; done SHALL be 0 in every other cycle.
REQ-017: A start asserted in the done cycle SHALL be accepted (busy=0), giving a first start bit in the next cycle with no extra idle bit.
REQ-018: Byte-level FSM states: IDLE, TAG, DATA; next byte index 0..3 selects the tag value (index+1) and the data slice word[8*index+7 : 8*index].
REQ-019: Bit-level FSM states: START, BITS (3-bit bit index 0..7), STOP; baud counter 0..CLKS_PER_BIT-1, wrap-around at CLKS_PER_BIT-1 advances the bit.
REQ-020: Transitions: IDLE->TAG(index 0) on accepted start; TAG->DATA and DATA->TAG(index+1) at end of stop bit; DATA(index 3)->IDLE at end of stop bit.
REQ-021: When idle, tx SHALL be 1 continuously.
REQ-022: The byte stream SHALL be decodable by the team's 32-bit word UART receiver at equal CLKS_PER_BIT, reproducing word.

Reset
REQ-023: While reset=1: tx=1, busy=0, done=0, FSMs=IDLE, counters and word register=0.
REQ-024: Reset asserted mid-transfer SHALL abort at the next edge (tx=1, busy=0, done=0) with no done pulse; the partial word SHALL NOT be resumed.
REQ-025: start asserted in the same cycle as reset SHALL be ignored.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-026: Reset, then start=1 for 1 cycle with word=0xDEADBEEF -> tx decodes as 01 EF 02 BE 03 AD 04 DE; done pulses 321 cycles after the accepting edge, once.
REQ-027: Bit timing: word=0x00000000 -> every tx low/high segment is a multiple of 4 cycles; the first byte 0x01 shows low 4 (start), high 4, low 28, high 4 (stop).
REQ-028: Start held high continuously with word changing each cycle -> words are sent back-to-back, each equal to the value present in its accepting cycle (the done cycle for all but the first); no gap in the tx stream.
REQ-029: Start pulsed mid-transfer with word=0x12345678 -> ignored; the current word completes unchanged and only one done pulse occurs.
REQ-030: Reset asserted during byte 3 (0xAD) -> next cycle tx=1, busy=0, no done; new start with 0xCAFEF00D sends the full sequence correctly.
REQ-031: Loopback into the 32-bit word UART receiver with CLKS_PER_BIT=16 and word=0xA5A5_0F0F -> receiver instr equals 0xA5A50F0F after done.
